// File: rtl/secuenciador_alu.sv
// secuenciador_alu
// Registered initiator for the combinational ALU. It accepts one command per
// valid/ready handshake and launches the operands and operation select to the
// ALU. It holds them for ESPERA settle cycles, then samples the ALU result and
// flags. The sampled values are returned over a second valid/ready handshake.
// An internal accumulator holds the last captured result, so commands can be
// chained by taking operand A from the previous result.
//
// Ports
//   reloj, reset            clock, asynchronous active-high reset
//   cmdValido / cmdListo    command handshake
//   cmdA, cmdB              operands (ancho+1 bits)
//   cmdSeleccion            ALU operation code, passed through unmodified
//   cmdAcumular             1 = take operand A from the accumulator
//   operandoA/B, seleccion  launched values toward the ALU
//   resultado, N, Z, C, V   ALU result and flags, sampled at capture
//   rspValido / rspListo    response handshake
//   rspResultado            captured result
//   rspBanderas             captured {N,Z,C,V}
//   ocupado                 high whenever the sequencer is not idle

module secuenciador_alu #(
  parameter int ancho  = 3,
  parameter int ESPERA = 2
) (
  input  logic           reloj,
  input  logic           reset,
  input  logic           cmdValido,
  output logic           cmdListo,
  input  logic [ancho:0] cmdA,
  input  logic [ancho:0] cmdB,
  input  logic [3:0]     cmdSeleccion,
  input  logic           cmdAcumular,
  output logic [ancho:0] operandoA,
  output logic [ancho:0] operandoB,
  output logic [3:0]     seleccion,
  input  logic [ancho:0] resultado,
  input  logic           N,
  input  logic           Z,
  input  logic           C,
  input  logic           V,
  output logic           rspValido,
  input  logic           rspListo,
  output logic [ancho:0] rspResultado,
  output logic [3:0]     rspBanderas,
  output logic           ocupado
);

  // The counter only has to hold ESPERA-1; keep at least one bit.
  localparam int CW = (ESPERA > 1) ? $clog2(ESPERA) : 1;
  localparam logic [CW-1:0] CARGA = CW'(ESPERA - 1);

  typedef enum logic [1:0] {
    REPOSO,
    EMITIR,
    RESPONDER
  } estado_t;

  estado_t        estado_q,       estado_d;
  logic [CW-1:0]  cuenta_q,       cuenta_d;
  logic [ancho:0] acumulador_q,   acumulador_d;
  logic [ancho:0] operandoA_q,    operandoA_d;
  logic [ancho:0] operandoB_q,    operandoB_d;
  logic [3:0]     seleccion_q,    seleccion_d;
  logic [ancho:0] rspResultado_q, rspResultado_d;
  logic [3:0]     rspBanderas_q,  rspBanderas_d;
  logic           cmdListo_q,     cmdListo_d;
  logic           rspValido_q,    rspValido_d;
  logic           ocupado_q,      ocupado_d;

  // State register. The handshake flags have their own flops so that every
  // output comes straight from a register. cmdListo resets to 1 because the
  // reset state is idle and ready for a command.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado_q       <= REPOSO;
      cuenta_q       <= '0;
      acumulador_q   <= '0;
      operandoA_q    <= '0;
      operandoB_q    <= '0;
      seleccion_q    <= '0;
      rspResultado_q <= '0;
      rspBanderas_q  <= '0;
      cmdListo_q     <= 1'b1;
      rspValido_q    <= 1'b0;
      ocupado_q      <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      cuenta_q       <= cuenta_d;
      acumulador_q   <= acumulador_d;
      operandoA_q    <= operandoA_d;
      operandoB_q    <= operandoB_d;
      seleccion_q    <= seleccion_d;
      rspResultado_q <= rspResultado_d;
      rspBanderas_q  <= rspBanderas_d;
      cmdListo_q     <= cmdListo_d;
      rspValido_q    <= rspValido_d;
      ocupado_q      <= ocupado_d;
    end
  end

  // Next-state logic. Every register holds by default. Each transition also
  // sets the flag values that belong to the state being entered, so the
  // flags always agree with estado_q.
  always_comb begin
    estado_d       = estado_q;
    cuenta_d       = cuenta_q;
    acumulador_d   = acumulador_q;
    operandoA_d    = operandoA_q;
    operandoB_d    = operandoB_q;
    seleccion_d    = seleccion_q;
    rspResultado_d = rspResultado_q;
    rspBanderas_d  = rspBanderas_q;
    cmdListo_d     = cmdListo_q;
    rspValido_d    = rspValido_q;
    ocupado_d      = ocupado_q;

    unique case (estado_q)
      REPOSO: begin
        if (cmdValido) begin
          operandoA_d = cmdAcumular ? acumulador_q : cmdA;
          operandoB_d = cmdB;
          seleccion_d = cmdSeleccion;
          cuenta_d    = CARGA;
          estado_d    = EMITIR;
          cmdListo_d  = 1'b0;
          ocupado_d   = 1'b1;
        end
      end

      EMITIR: begin
        // Capture on the edge where the counter has reached zero. This gives
        // exactly ESPERA edges between launch and capture.
        if (cuenta_q == '0) begin
          rspResultado_d = resultado;
          rspBanderas_d  = {N, Z, C, V};
          acumulador_d   = resultado;
          estado_d       = RESPONDER;
          rspValido_d    = 1'b1;
        end else begin
          cuenta_d = cuenta_q - 1'b1;
        end
      end

      RESPONDER: begin
        if (rspListo) begin
          estado_d    = REPOSO;
          rspValido_d = 1'b0;
          cmdListo_d  = 1'b1;
          ocupado_d   = 1'b0;
        end
      end

      default: begin
        estado_d    = REPOSO;
        cmdListo_d  = 1'b1;
        rspValido_d = 1'b0;
        ocupado_d   = 1'b0;
      end
    endcase
  end

  assign cmdListo     = cmdListo_q;
  assign operandoA    = operandoA_q;
  assign operandoB    = operandoB_q;
  assign seleccion    = seleccion_q;
  assign rspValido    = rspValido_q;
  assign rspResultado = rspResultado_q;
  assign rspBanderas  = rspBanderas_q;
  assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_secuenciador_alu.sv
// tb_secuenciador_alu
// Directed bench for secuenciador_alu with ancho=3 and ESPERA=2. An adder stub
// stands in for the ALU. The bench checks the reset values, command-to-response
// latency, flag capture, accumulator chaining, reset in the middle of a command,
// backpressure and back-to-back throughput.

module tb_secuenciador_alu;

  logic       reloj;
  logic       reset;
  logic       cmdValido;
  logic       cmdListo;
  logic [3:0] cmdA;
  logic [3:0] cmdB;
  logic [3:0] cmdSeleccion;
  logic       cmdAcumular;
  logic [3:0] operandoA;
  logic [3:0] operandoB;
  logic [3:0] seleccion;
  logic [3:0] resultado;
  logic       N, Z, C, V;
  logic       rspValido;
  logic       rspListo;
  logic [3:0] rspResultado;
  logic [3:0] rspBanderas;
  logic       ocupado;

  int testsRun    = 0;
  int testsFailed = 0;

  secuenciador_alu #(.ancho(3), .ESPERA(2)) dut (
    .reloj        (reloj),
    .reset        (reset),
    .cmdValido    (cmdValido),
    .cmdListo     (cmdListo),
    .cmdA         (cmdA),
    .cmdB         (cmdB),
    .cmdSeleccion (cmdSeleccion),
    .cmdAcumular  (cmdAcumular),
    .operandoA    (operandoA),
    .operandoB    (operandoB),
    .seleccion    (seleccion),
    .resultado    (resultado),
    .N            (N),
    .Z            (Z),
    .C            (C),
    .V            (V),
    .rspValido    (rspValido),
    .rspListo     (rspListo),
    .rspResultado (rspResultado),
    .rspBanderas  (rspBanderas),
    .ocupado      (ocupado)
  );

  // Adder stub standing in for the ALU: 4-bit sum with N/Z/C/V flags.
  logic [4:0] suma;
  assign suma      = {1'b0, operandoA} + {1'b0, operandoB};
  assign resultado = suma[3:0];
  assign N         = suma[3];
  assign Z         = (suma[3:0] == 4'd0);
  assign C         = suma[4];
  assign V         = (operandoA[3] == operandoB[3]) && (suma[3] != operandoA[3]);

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  // Watchdog so that a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one command for a single edge. The caller makes sure the DUT is
  // idle, so the command is accepted at the posedge inside this task.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] sel, input logic acc);
    @(negedge reloj);
    cmdA         = a;
    cmdB         = b;
    cmdSeleccion = sel;
    cmdAcumular  = acc;
    cmdValido    = 1'b1;
    @(posedge reloj);
    #1 cmdValido = 1'b0;
  endtask

  // Full command with the consumer always ready. The accept edge is k: the
  // response is visible after k+2 and the block is idle again after k+3.
  task automatic runOp(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic acc, input logic [3:0] expA,
                       input logic [3:0] expRes, input logic [3:0] expFlags);
    rspListo = 1'b1;
    applyStimulus(a, b, 4'd0, acc);
    @(negedge reloj);
    checkOutput({tag, ".opA"},     operandoA, expA);
    checkOutput({tag, ".opB"},     operandoB, b);
    checkOutput({tag, ".busyLo"},  {cmdListo, ocupado, rspValido}, 3'b010);
    @(negedge reloj);
    checkOutput({tag, ".settle"},  rspValido, 1'b0);
    @(negedge reloj);
    checkOutput({tag, ".valid"},   rspValido, 1'b1);
    checkOutput({tag, ".res"},     rspResultado, expRes);
    checkOutput({tag, ".flags"},   rspBanderas, expFlags);
    @(negedge reloj);
    checkOutput({tag, ".done"},    {cmdListo, ocupado, rspValido}, 3'b100);
  endtask

  initial begin
    logic seen;
    logic stable;
    int   accepts[$];

    reset        = 1'b1;
    cmdValido    = 1'b0;
    cmdA         = 4'd0;
    cmdB         = 4'd0;
    cmdSeleccion = 4'd0;
    cmdAcumular  = 1'b0;
    rspListo     = 1'b0;

    // Reset values
    repeat (2) @(negedge reloj);
    reset = 1'b0;
    @(negedge reloj);
    checkOutput("rst.opA",   operandoA, 4'd0);
    checkOutput("rst.opB",   operandoB, 4'd0);
    checkOutput("rst.sel",   seleccion, 4'd0);
    checkOutput("rst.res",   rspResultado, 4'd0);
    checkOutput("rst.flags", rspBanderas, 4'd0);
    checkOutput("rst.ctl",   {cmdListo, ocupado, rspValido}, 3'b100);

    // Single op and flag cases
    runOp("single", 4'd3, 4'd4, 1'b0, 4'd3, 4'd7,  4'b0000);
    runOp("zc",     4'd9, 4'd7, 1'b0, 4'd9, 4'd0,  4'b0110);
    runOp("nv",     4'd7, 4'd1, 1'b0, 4'd7, 4'd8,  4'b1001);

    // Accumulator chaining: the second command ignores cmdA=15
    runOp("acc1",   4'd5,  4'd2, 1'b0, 4'd5, 4'd7,  4'b0000);
    runOp("acc2",   4'd15, 4'd3, 1'b1, 4'd7, 4'd10, 4'b1001);

    // Reset in the middle of the settle window
    rspListo = 1'b1;
    applyStimulus(4'd6, 4'd6, 4'd0, 1'b0);
    #2 reset = 1'b1;
    @(negedge reloj);
    checkOutput("midRst.opA", operandoA, 4'd0);
    checkOutput("midRst.ctl", {cmdListo, ocupado, rspValido}, 3'b100);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge reloj);
      if (rspValido) seen = 1'b1;
    end
    checkOutput("midRst.noRsp", seen, 1'b0);
    checkOutput("midRst.res",   rspResultado, 4'd0);
    // The accumulator was cleared, so chaining now starts from 0.
    runOp("postRst", 4'd9, 4'd6, 1'b1, 4'd0, 4'd6, 4'b0000);

    // Backpressure: the response is held and new commands are ignored
    rspListo = 1'b0;
    applyStimulus(4'd2, 4'd3, 4'd0, 1'b0);
    repeat (2) @(negedge reloj);
    @(negedge reloj);
    checkOutput("bp.valid", rspValido, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmdA      = 4'd15;
      cmdValido = 1'b1;
      @(negedge reloj);
      if (!rspValido || rspResultado != 4'd5 || rspBanderas != 4'd0 ||
          operandoA != 4'd2 || cmdListo) stable = 1'b0;
    end
    checkOutput("bp.stable", stable, 1'b1);
    cmdValido = 1'b0;
    rspListo  = 1'b1;
    @(negedge reloj);
    checkOutput("bp.release", {cmdListo, ocupado, rspValido}, 3'b100);
    @(negedge reloj);
    checkOutput("bp.single",  {cmdListo, ocupado, rspValido}, 3'b100);

    // Throughput: valid and ready held high, one accept every 4 cycles
    cmdA         = 4'd1;
    cmdB         = 4'd1;
    cmdSeleccion = 4'd9;
    cmdAcumular  = 1'b0;
    rspListo     = 1'b1;
    cmdValido    = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (cmdListo) accepts.push_back(c);
      @(posedge reloj);
      @(negedge reloj);
    end
    cmdValido = 1'b0;
    checkOutput("tp.count", accepts.size(), 4);
    for (int i = 1; i < accepts.size(); i++)
      checkOutput("tp.gap", accepts[i] - accepts[i-1], 4);
    checkOutput("tp.sel", seleccion, 4'd9);
    checkOutput("tp.opA", operandoA, 4'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge reloj);
      if (cmdListo && !ocupado && !rspValido) seen = 1'b1;
    end
    checkOutput("tp.drain", seen, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/secuenciador_alu.md
# secuenciador_alu

Registered initiator for the combinational ALU. It accepts one command per valid/ready handshake and drives the operands and operation select into the ALU. It holds them stable for a fixed settle window, then samples the ALU result and N/Z/C/V flags. The sampled values are returned over a second valid/ready handshake. It sits between the lab's command source (switch/button front-end or test sequencer) and the ALU, adding a result accumulator so operations can be chained.

## Interface
Parameters:
- ancho, 3, MSB index of data paths (data width is ancho+1 bits)
- ESPERA, 2, ALU settle cycles between operand launch and result capture (legal range ≥1)

Ports:
- reloj  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- cmdValido  input  1  command present
- cmdListo  output  1  block can accept a command
- cmdA  input  ancho+1  operand A
- cmdB  input  ancho+1  operand B
- cmdSeleccion  input  4  ALU operation code, passed through unmodified
- cmdAcumular  input  1  1 = use accumulator as operand A, ignore cmdA
- operandoA  output  ancho+1  to ALU operandoA
- operandoB  output  ancho+1  to ALU operandoB
- seleccion  output  4  to ALU seleccion
- resultado  input  ancho+1  from ALU
- N, Z, C, V  input  1 each  from ALU
- rspValido  output  1  response present
- rspListo  input  1  consumer accepts response
- rspResultado  output  ancho+1  captured result
- rspBanderas  output  4  captured {N,Z,C,V}
- ocupado  output  1  high whenever state ≠ REPOSO

## Operation
- FSM with three states: REPOSO, EMITIR, RESPONDER. All outputs come from registers.
- REPOSO:
  - cmdListo=1.
  - On an edge with cmdValido=1, latch the command:
    - operandoA ← (cmdAcumular ? acumulador : cmdA)
    - operandoB ← cmdB
    - seleccion ← cmdSeleccion
  - Load the settle counter with ESPERA-1 and go to EMITIR.
- EMITIR:
  - cmdListo=0; operand outputs are held.
  - The counter decrements each edge.
  - On the edge where the counter is 0, perform the capture and go to RESPONDER:
    - rspResultado ← resultado
    - rspBanderas ← {N,Z,C,V}
    - acumulador ← resultado
- RESPONDER:
  - rspValido=1. rspResultado and rspBanderas are stable until the handshake.
  - On an edge with rspListo=1, go to REPOSO.
  - cmdValido is ignored in this state.
- Operand outputs keep their last launched values after returning to REPOSO, until the next command is accepted.
- The accumulator is internal, ancho+1 bits, and updated only at capture. cmdAcumular on the first command after reset uses 0.
- No arithmetic is performed in this block. Width is preserved; there is no truncation or extension.
- Reset (asynchronous, any state, including mid-EMITIR or mid-RESPONDER):
  - state=REPOSO, counter=0, acumulador=0.
  - operandoA, operandoB, seleccion, rspResultado, rspBanderas = 0.
  - rspValido=0, ocupado=0, cmdListo=1 once reset deasserts.
  - An in-flight command is discarded with no response.

## Timing
- Command accepted at edge k. Operands are visible at the ALU from just after edge k.
- Capture at edge k+ESPERA. rspValido=1 from just after edge k+ESPERA.
- Response handshake at the first edge ≥k+ESPERA+1 with rspListo=1. rspValido drops and cmdListo rises after that edge.
- Minimum command period is ESPERA+2 cycles: accept, ESPERA settle cycles, response edge, back to REPOSO. Command acceptance and response acceptance never occur on the same edge.
- A consumer holding rspListo=0 stalls the block indefinitely. The response is held unchanged and no commands are accepted.
- ALU inputs are sampled only at the capture edge. Glitches during settle are irrelevant.

## Test plan
Bench ALU stub: resultado=operandoA+operandoB mod 16, N=msb, Z=(resultado==0), C=carry, V=signed overflow. ancho=3, ESPERA=2.
- Reset: after reset, all outputs are 0 and cmdListo=1. Assert reset mid-EMITIR → rspValido never rises, and the next command works normally.
- Single op: cmdA=3, cmdB=4, rspListo=1, accepted at edge k → rspValido high after edge k+2, rspResultado=7, rspBanderas=4'b0000, cmdListo=1 after edge k+3.
- Flags: A=9, B=7 → resultado=0, rspBanderas=4'b0110 (Z,C). A=7, B=1 → resultado=8, rspBanderas=4'b1001 (N,V).
- Accumulate: A=5, B=2 (result 7), then cmdAcumular=1, cmdA=15, B=3 → operandoA=7, result 10.
- Backpressure: rspListo=0 for 5 cycles → rspValido and rspResultado stay stable, and cmdValido pulses are ignored. Release → exactly one handshake.
- Throughput: cmdValido and rspListo held at 1 → commands are accepted every 4 cycles, and seleccion passes through unchanged (drive 4'd9 → seleccion=4'd9).
